// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and sizing helper for the round-robin arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/lsb_first_pick.sv
// rtl/lsb_first_pick.sv - combinational lowest-index-wins picker with one-hot and binary outputs
module lsb_first_pick
  import arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BIN_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out_onehot,
  output logic [BIN_W-1:0] out_bin,
  output logic             out_any
);

  // Scan from the top down so the lowest set bit is the last one written and wins.
  always_comb begin
    out_onehot = '0;
    out_bin    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in[i]) begin
        out_onehot    = '0;
        out_onehot[i] = 1'b1;
        out_bin       = BIN_W'(i);
      end
    end
  end

  assign out_any = |in;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with grant hold, turnaround gap and hold timeout
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int IDX_W    = clog2(N),
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_bin,
  output logic             o_active,
  output logic             o_timeout
);

  // Last hold_cnt value of a grant; only meaningful when a timeout is configured.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [IDX_W-1:0] gnt_bin_nxt;
  logic             active_nxt;
  logic             timeout_nxt;

  logic [N-1:0]     masked;
  logic [N-1:0]     m_onehot, r_onehot, win_onehot;
  logic [IDX_W-1:0] m_bin, r_bin, win_bin;
  logic             m_any, r_any;
  logic             owner_req;

  // Keep only requesters at or above the rotating pointer.
  always_comb begin
    masked = '0;
    for (int k = 0; k < N; k++) begin
      masked[k] = i_req[k] && (k >= int'(ptr));
    end
  end

  lsb_first_pick #(.WIDTH(N), .BIN_W(IDX_W)) u_pick_masked (
    .in         (masked),
    .out_onehot (m_onehot),
    .out_bin    (m_bin),
    .out_any    (m_any)
  );

  lsb_first_pick #(.WIDTH(N), .BIN_W(IDX_W)) u_pick_raw (
    .in         (i_req),
    .out_onehot (r_onehot),
    .out_bin    (r_bin),
    .out_any    (r_any)
  );

  // Nothing at or above ptr means the search wraps to the lowest raw request.
  assign win_onehot = m_any ? m_onehot : r_onehot;
  assign win_bin    = m_any ? m_bin    : r_bin;

  // Only the current owner's request matters while a grant is held.
  assign owner_req  = |(i_req & o_gnt);

  // Next-state and next-output decode; every target starts from its held value.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = o_gnt;
    gnt_bin_nxt  = o_gnt_bin;
    active_nxt   = o_active;
    timeout_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (r_any) begin
          state_nxt    = ST_GRANT;
          gnt_nxt      = win_onehot;
          gnt_bin_nxt  = win_bin;
          active_nxt   = 1'b1;
          hold_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST))) begin
          state_nxt   = ST_GAP;
          gnt_nxt     = '0;
          active_nxt  = 1'b0;
          // A release with the owner still requesting can only be the timeout cut.
          timeout_nxt = owner_req;
          ptr_nxt     = (o_gnt_bin == LAST_IDX) ? '0 : o_gnt_bin + 1'b1;
        end else if (hold_cnt != '1) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pointer, counter and output registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      o_gnt     <= '0;
      o_gnt_bin <= '0;
      o_active  <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_cnt_nxt;
      o_gnt     <= gnt_nxt;
      o_gnt_bin <= gnt_bin_nxt;
      o_active  <= active_nxt;
      o_timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking scoreboard bench for rr_arbiter
`timescale 1ns/1ps
module tb_rr_arbiter;

  localparam int N        = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 15;
  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = N * (MAX_HOLD + 2);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     o_gnt;
  logic [IDX_W-1:0] o_gnt_bin;
  logic             o_active;
  logic             o_timeout;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  rr_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .o_gnt     (o_gnt),
    .o_gnt_bin (o_gnt_bin),
    .o_active  (o_active),
    .o_timeout (o_timeout)
  );

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++) begin
      if (r[(p + j) % N]) return (p + j) % N;
    end
    return -1;
  endfunction

  task automatic apply_reset(input logic [N-1:0] r);
    rst = 1'b1;
    req = r;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_active) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'hFF;
    repeat (3) @(negedge clk);
    tests++; if (o_gnt !== 8'h00) begin fails++; $display("FAIL reset_gnt: got %h expected 00", o_gnt); end
    tests++; if (o_active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b expected 0", o_active); end
    tests++; if (o_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", o_timeout); end
    tests++; if (o_gnt_bin !== 3'd0) begin fails++; $display("FAIL reset_bin: got %0d expected 0", o_gnt_bin); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (o_gnt !== 8'h01) begin fails++; $display("FAIL reset_first_grant: got %h expected 01", o_gnt); end
    tests++; if (o_active !== 1'b1) begin fails++; $display("FAIL reset_first_active: got %b expected 1", o_active); end
    req = '0;
  endtask

  task automatic test_rotation();
    bit ok;
    int exp_idx;
    logic [N-1:0] exp_oh;
    apply_reset(8'hFF);
    for (int i = 0; i <= N; i++) exp_q.push_back(i % N);
    while (exp_q.size() > 0) begin
      wait_grant(ok);
      exp_idx = exp_q.pop_front();
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL rotation_wait: got no grant expected grant %0d", exp_idx);
        exp_q.delete();
      end else begin
        exp_oh = '0;
        exp_oh[exp_idx] = 1'b1;
        if (o_gnt !== exp_oh) begin fails++; $display("FAIL rotation_gnt: got %h expected %h", o_gnt, exp_oh); end
        tests++;
        if (o_gnt_bin !== IDX_W'(exp_idx)) begin fails++; $display("FAIL rotation_bin: got %0d expected %0d", o_gnt_bin, exp_idx); end
        req = 8'hFF & ~o_gnt;
        @(negedge clk);
        req = 8'hFF;
      end
    end
    req = '0;
  endtask

  task automatic test_wrap_skip();
    bit ok;
    int exp_idx;
    apply_reset(8'h20);
    wait_grant(ok);
    tests++; if (!ok || o_gnt_bin !== 3'd5) begin fails++; $display("FAIL wrap_setup: got %0d expected 5", o_gnt_bin); end
    req = 8'b0000_0101;
    exp_q.push_back(0);
    exp_q.push_back(2);
    wait_grant(ok);
    exp_idx = exp_q.pop_front();
    tests++; if (!ok || o_gnt_bin !== IDX_W'(exp_idx)) begin fails++; $display("FAIL wrap_first_bin: got %0d expected %0d", o_gnt_bin, exp_idx); end
    tests++; if (o_gnt !== 8'h01) begin fails++; $display("FAIL wrap_first_gnt: got %h expected 01", o_gnt); end
    req = 8'b0000_0100;
    wait_grant(ok);
    exp_idx = exp_q.pop_front();
    tests++; if (!ok || o_gnt_bin !== IDX_W'(exp_idx)) begin fails++; $display("FAIL wrap_second_bin: got %0d expected %0d", o_gnt_bin, exp_idx); end
    tests++; if (o_gnt !== 8'h04) begin fails++; $display("FAIL wrap_second_gnt: got %h expected 04", o_gnt); end
    req = '0;
  endtask

  task automatic test_timeout();
    bit ok;
    int exp_idx;
    int len;
    apply_reset(8'h09);
    exp_q.push_back(0);
    exp_q.push_back(3);
    wait_grant(ok);
    exp_idx = exp_q.pop_front();
    tests++; if (!ok || o_gnt_bin !== IDX_W'(exp_idx)) begin fails++; $display("FAIL timeout_first_bin: got %0d expected %0d", o_gnt_bin, exp_idx); end
    len = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_active) len++;
      else break;
    end
    tests++; if (len != MAX_HOLD) begin fails++; $display("FAIL timeout_hold_len: got %0d expected %0d", len, MAX_HOLD); end
    tests++; if (o_timeout !== 1'b1) begin fails++; $display("FAIL timeout_pulse: got %b expected 1", o_timeout); end
    @(negedge clk);
    tests++; if (o_timeout !== 1'b0) begin fails++; $display("FAIL timeout_pulse_width: got %b expected 0", o_timeout); end
    wait_grant(ok);
    exp_idx = exp_q.pop_front();
    tests++; if (!ok || o_gnt_bin !== IDX_W'(exp_idx)) begin fails++; $display("FAIL timeout_next_bin: got %0d expected %0d", o_gnt_bin, exp_idx); end
    req = '0;
  endtask

  task automatic test_async_reset();
    bit ok;
    apply_reset(8'hFF);
    wait_grant(ok);
    req = 8'hFE;
    @(negedge clk);
    req = 8'hFF;
    wait_grant(ok);
    tests++; if (!ok || o_gnt_bin !== 3'd1) begin fails++; $display("FAIL areset_setup: got %0d expected 1", o_gnt_bin); end
    repeat (14) @(negedge clk);
    tests++; if (o_active !== 1'b1) begin fails++; $display("FAIL areset_still_held: got %b expected 1", o_active); end
    #1 rst = 1'b1;
    #1;
    tests++; if (o_gnt !== 8'h00) begin fails++; $display("FAIL areset_gnt: got %h expected 00", o_gnt); end
    tests++; if (o_active !== 1'b0) begin fails++; $display("FAIL areset_active: got %b expected 0", o_active); end
    tests++; if (o_timeout !== 1'b0) begin fails++; $display("FAIL areset_timeout: got %b expected 0", o_timeout); end
    #1 rst = 1'b0;
    exp_q.push_back(0);
    wait_grant(ok);
    tests++; if (!ok || o_gnt_bin !== IDX_W'(exp_q.pop_front())) begin fails++; $display("FAIL areset_ptr: got %0d expected 0", o_gnt_bin); end
    tests++; if (o_timeout !== 1'b0) begin fails++; $display("FAIL areset_no_pulse: got %b expected 0", o_timeout); end
    req = '0;
  endtask

  task automatic test_random();
    int exp_idx, ptr_m, len, idle_len, max_wait, prev_bin;
    bit prev_active, exp_to;
    logic [N-1:0] req_last, exp_oh;
    int wait_cnt[N];
    apply_reset('0);
    exp_q.delete();
    ptr_m = 0; len = 0; idle_len = 2; prev_bin = 0; prev_active = 1'b0;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      req_last = req;
      exp_idx = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      exp_oh = '0;
      if (o_active) exp_oh[o_gnt_bin] = 1'b1;
      tests++; if (o_gnt !== exp_oh) begin fails++; $display("FAIL rand_onehot: got %h expected %h", o_gnt, exp_oh); end
      if (o_active && !prev_active) begin
        tests++; if (exp_idx < 0 || o_gnt_bin !== IDX_W'(exp_idx)) begin fails++; $display("FAIL rand_winner: got %0d expected %0d", o_gnt_bin, exp_idx); end
        tests++; if (idle_len < 2) begin fails++; $display("FAIL rand_gap: got %0d idle cycles expected at least 2", idle_len); end
        len = 1;
      end else if (o_active) begin
        len++;
      end
      exp_to = 1'b0;
      if (!o_active && prev_active) begin
        exp_to = (len == MAX_HOLD) && req_last[prev_bin];
        ptr_m = (prev_bin + 1) % N;
        idle_len = 1;
      end else if (!o_active) begin
        idle_len++;
      end
      tests++; if (o_timeout !== exp_to) begin fails++; $display("FAIL rand_timeout: got %b expected %b", o_timeout, exp_to); end
      tests++; if (o_active && len > MAX_HOLD) begin fails++; $display("FAIL rand_hold: got %0d cycles expected at most %0d", len, MAX_HOLD); end
      max_wait = 0;
      for (int k = 0; k < N; k++) begin
        if (req_last[k] && !(o_active && o_gnt_bin == IDX_W'(k))) wait_cnt[k]++;
        else wait_cnt[k] = 0;
        if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
      end
      tests++; if (max_wait > WAIT_MAX) begin fails++; $display("FAIL rand_starve: got %0d cycles expected at most %0d", max_wait, WAIT_MAX); end
      prev_active = o_active;
      if (o_active) prev_bin = int'(o_gnt_bin);
      if ($urandom_range(7) == 0) req = N'($urandom);
      else if (o_active && $urandom_range(5) == 0) req[o_gnt_bin] = 1'b0;
      exp_q.push_back(pick(req, ptr_m));
    end
    req = '0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
